npn_tt_sweep_ctrl: RTL and testbench



---
 rtl/npn_tt_sweep_ctrl.sv | 157 +++++++++++++++
 tb/tb_npn_tt_sweep_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/npn_tt_sweep_ctrl.sv
// npn_tt_sweep_ctrl: walks all 2^NUM_IN minterms through a shared function
// unit, builds the observed truth table from y0 and scores it against the
// expected table captured at start.
// Optional build macro: NPN_SWEEP_FIRST_FAIL_EN adds first-mismatch capture.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start_valid_i; start_ready_o high
// S_RUN  | driving x_o, sampling y0_i every SETTLE cycles
// S_DONE | one-cycle completion pulse; pass_o valid
module npn_tt_sweep_ctrl #(
  parameter  int NUM_IN = 4,
  parameter  int SETTLE = 1,
  localparam int TT_W   = 2**NUM_IN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [TT_W-1:0]   exp_tt_i,
  input  logic              abort_i,
  output logic [NUM_IN-1:0] x_o,
  input  logic              y0_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [TT_W-1:0]   tt_o,
  output logic [NUM_IN:0]   mism_cnt_o
`ifdef NPN_SWEEP_FIRST_FAIL_EN
  ,
  output logic              first_fail_vld_o,
  output logic [NUM_IN-1:0] first_fail_idx_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0]        HOLD_LAST = 4'(SETTLE - 1);
  localparam logic [3:0]        HOLD_ONE  = 4'd1;
  localparam logic [NUM_IN-1:0] X_ONE     = NUM_IN'(1);
  localparam logic [NUM_IN:0]   MISM_ONE  = (NUM_IN+1)'(1);

  state_t              state_q, state_d;
  logic [NUM_IN-1:0]   x_q, x_d;
  logic [3:0]          hold_q, hold_d;
  logic [TT_W-1:0]     exp_q, exp_d;
  logic [TT_W-1:0]     tt_q, tt_d;
  logic [NUM_IN:0]     mism_q, mism_d;
  logic                pass_q, pass_d;
  logic                ffv_q, ffv_d;
  logic [NUM_IN-1:0]   ffi_q, ffi_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      hold_q  <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      mism_q  <= '0;
      pass_q  <= 1'b0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      hold_q  <= hold_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      mism_q  <= mism_d;
      pass_q  <= pass_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
    end
  end

  // Next-state logic: accept, per-minterm sampling, abort and completion.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    hold_d  = hold_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    mism_d  = mism_q;
    pass_d  = pass_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid_i) begin
          exp_d   = exp_tt_i;
          tt_d    = '0;
          mism_d  = '0;
          pass_d  = 1'b0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
          x_d     = '0;
          hold_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          // Abort outranks a coincident final sample.
          state_d = S_IDLE;
          x_d     = '0;
          hold_d  = '0;
          tt_d    = '0;
          mism_d  = '0;
          pass_d  = 1'b0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
        end else if (hold_q == HOLD_LAST) begin
          tt_d[x_q] = y0_i;
          hold_d    = '0;
          if (y0_i != exp_q[x_q]) begin
            mism_d = mism_q + MISM_ONE;
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = x_q;
            end
          end
          if (&x_q) begin
            state_d = S_DONE;
            x_d     = '0;
            pass_d  = (mism_d == '0);
          end else begin
            x_d = x_q + X_ONE;
          end
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign start_ready_o = (state_q == S_IDLE);
  assign busy_o        = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign x_o           = x_q;
  assign pass_o        = pass_q;
  assign tt_o          = tt_q;
  assign mism_cnt_o    = mism_q;

`ifdef NPN_SWEEP_FIRST_FAIL_EN
  assign first_fail_vld_o = ffv_q;
  assign first_fail_idx_o = ffi_q;
`else
  // First-fail tracking has no consumer in this build.
  logic unused_ff;
  assign unused_ff = ffv_q ^ (^ffi_q);
`endif

endmodule

// File: tb/tb_npn_tt_sweep_ctrl.sv
// Directed bench for npn_tt_sweep_ctrl: two instances (SETTLE=1, SETTLE=3),
// each feeding a 4-input XOR model back into y0.
module tb_npn_tt_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // dut1: SETTLE=1
  logic        sv1 = 1'b0, ab1 = 1'b0;
  logic [15:0] exp1 = '0;
  logic        rdy1, busy1, done1, pass1, y1;
  logic [3:0]  x1;
  logic [15:0] tt1;
  logic [4:0]  mc1;
  // dut3: SETTLE=3
  logic        sv3 = 1'b0, ab3 = 1'b0;
  logic [15:0] exp3 = '0;
  logic        rdy3, busy3, done3, pass3, y3;
  logic [3:0]  x3;
  logic [15:0] tt3;
  logic [4:0]  mc3;
`ifdef NPN_SWEEP_FIRST_FAIL_EN
  logic        ffv1, ffv3;
  logic [3:0]  ffi1, ffi3;
`endif

  assign y1 = ^x1;
  assign y3 = ^x3;

  npn_tt_sweep_ctrl #(.NUM_IN(4), .SETTLE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_valid_i(sv1), .start_ready_o(rdy1),
    .exp_tt_i(exp1), .abort_i(ab1), .x_o(x1), .y0_i(y1), .busy_o(busy1),
    .done_o(done1), .pass_o(pass1), .tt_o(tt1), .mism_cnt_o(mc1)
`ifdef NPN_SWEEP_FIRST_FAIL_EN
    , .first_fail_vld_o(ffv1), .first_fail_idx_o(ffi1)
`endif
  );

  npn_tt_sweep_ctrl #(.NUM_IN(4), .SETTLE(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .start_valid_i(sv3), .start_ready_o(rdy3),
    .exp_tt_i(exp3), .abort_i(ab3), .x_o(x3), .y0_i(y3), .busy_o(busy3),
    .done_o(done3), .pass_o(pass3), .tt_o(tt3), .mism_cnt_o(mc3)
`ifdef NPN_SWEEP_FIRST_FAIL_EN
    , .first_fail_vld_o(ffv3), .first_fail_idx_o(ffi3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Full sweep on dut1 with cycle-exact checks; optional stray start while busy.
  task automatic sweep1(input logic [15:0] e, input bit stray,
                        input logic [15:0] w_tt, input logic [4:0] w_mc,
                        input logic w_pass, input logic [3:0] w_ffi);
    @(negedge clk); sv1 = 1'b1; exp1 = e;
    @(negedge clk); sv1 = 1'b0;
    chk("clr_tt", tt1, 0);
    chk("clr_mc", mc1, 0);
    chk("clr_pass", pass1, 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("x1_%0d", k), x1, k);
      chk("busy1", busy1, 1);
      chk("rdy1_run", rdy1, 0);
      chk("done1_run", done1, 0);
      if (stray && k == 3) begin sv1 = 1'b1; exp1 = 16'h0000; end
      @(negedge clk);
      sv1 = 1'b0;
    end
    chk("done1", done1, 1);
    chk("busy1_done", busy1, 0);
    chk("x1_done", x1, 0);
    chk("pass1", pass1, w_pass);
    chk("tt1", tt1, w_tt);
    chk("mc1", mc1, w_mc);
`ifdef NPN_SWEEP_FIRST_FAIL_EN
    chk("ffv1", ffv1, (w_mc != 0));
    chk("ffi1", ffi1, w_ffi);
`else
    chk("ffi_unused", 32'(w_ffi), 32'(w_ffi & 4'hF));
`endif
    @(negedge clk);
    chk("rdy1_after", rdy1, 1);
    chk("done1_after", done1, 0);
    chk("tt1_hold", tt1, w_tt);
    chk("mc1_hold", mc1, w_mc);
    chk("pass1_hold", pass1, w_pass);
  endtask

  initial begin
    bit saw_done;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Reset state
    chk("rst_rdy", rdy1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_x", x1, 0);
    chk("rst_tt", tt1, 0);
    chk("rst_mc", mc1, 0);
    chk("rst_rdy3", rdy3, 1);

    // Case 1: match
    sweep1(16'h6996, 1'b0, 16'h6996, 5'd0, 1'b1, 4'd0);
    // Case 2: single mismatch at minterm 0
    sweep1(16'h6997, 1'b0, 16'h6996, 5'd1, 1'b0, 4'd0);
    // Case 3: all wrong
    sweep1(16'h9669, 1'b0, 16'h6996, 5'h10, 1'b0, 4'd0);
    // Two mismatches (minterms 1 and 2); first fail is 1
    sweep1(16'h6990, 1'b0, 16'h6996, 5'd2, 1'b0, 4'd1);
    // Case 5b: stray start while busy is ignored
    sweep1(16'h6996, 1'b1, 16'h6996, 5'd0, 1'b1, 4'd0);

    // Case 5a: abort at x=5 after some mismatches have accumulated
    @(negedge clk); sv1 = 1'b1; exp1 = 16'h0000;
    @(negedge clk); sv1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("ab_x5", x1, 5);
    chk("ab_mc_pre", mc1, 3);
    ab1 = 1'b1;
    @(negedge clk); ab1 = 1'b0;
    chk("ab_busy", busy1, 0);
    chk("ab_rdy", rdy1, 1);
    chk("ab_x", x1, 0);
    chk("ab_done", done1, 0);
    chk("ab_tt", tt1, 0);
    chk("ab_mc", mc1, 0);
    chk("ab_pass", pass1, 0);
`ifdef NPN_SWEEP_FIRST_FAIL_EN
    chk("ab_ffv", ffv1, 0);
`endif
    saw_done = 1'b0;
    repeat (20) begin @(negedge clk); saw_done |= done1; end
    chk("ab_nodone", saw_done, 0);

    // Case 6: reset at x=9
    @(negedge clk); sv1 = 1'b1; exp1 = 16'h0000;
    @(negedge clk); sv1 = 1'b0;
    repeat (9) @(negedge clk);
    chk("rr_x9", x1, 9);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rr_rdy", rdy1, 1);
    chk("rr_busy", busy1, 0);
    chk("rr_done", done1, 0);
    chk("rr_x", x1, 0);
    chk("rr_tt", tt1, 0);
    chk("rr_mc", mc1, 0);
    chk("rr_pass", pass1, 0);
    sweep1(16'h6996, 1'b0, 16'h6996, 5'd0, 1'b1, 4'd0);

    // Case 4: SETTLE=3, done at T+49
    @(negedge clk); sv3 = 1'b1; exp3 = 16'h6996;
    @(negedge clk); sv3 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int h = 0; h < 3; h++) begin
        chk($sformatf("x3_%0d_%0d", k, h), x3, k);
        chk("busy3", busy3, 1);
        @(negedge clk);
      end
    end
    chk("done3", done3, 1);
    chk("pass3", pass3, 1);
    chk("tt3", tt3, 16'h6996);
    chk("mc3", mc3, 0);
    @(negedge clk);
    chk("rdy3_after", rdy3, 1);
    chk("done3_after", done3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
